// File: rtl/apb_cmd_master.sv
// Single-command APB master: one SETUP+ACCESS per command, 4 cycles minimum, pready wait states and a timeout.
// Backpressure: cmd_ready only in IDLE; the response is held until rsp_ready, and no new command is taken before that.
module apb_cmd_master #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              prstn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   output logic              pwrite,
   output logic              psel,
   output logic              penable,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   // The counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   logic [1:0]        state_q,     state_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   logic [ADDR_W-1:0] paddr_q,     paddr_d;
   logic [DATA_W-1:0] pwdata_q,    pwdata_d;
   logic              pwrite_q,    pwrite_d;
   logic              psel_q,      psel_d;
   logic              penable_q,   penable_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q,   rsp_err_d;
   logic              xfer_done;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pwrite_d    = pwrite_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      xfer_done   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               paddr_d  = cmd_addr;
               pwdata_d = cmd_wdata;
               pwrite_d = cmd_write;
               psel_d   = 1'b1;
               state_d  = S_SETUP;
            end
         end
         S_SETUP: begin
            penable_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_ACCESS;
         end
         S_ACCESS: begin
            // pready is checked first so a slave answering on the last allowed cycle still succeeds.
            if (pready) begin
               rsp_rdata_d = pwrite_q ? '0 : prdata;
               rsp_err_d   = 1'b0;
               xfer_done   = 1'b1;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               xfer_done   = 1'b1;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (xfer_done) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!prstn) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pwrite_q    <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pwrite_q    <= pwrite_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Gated by prstn so the bridge never advertises readiness while held in reset.
   assign cmd_ready = (state_q == S_IDLE) && prstn;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign pwrite    = pwrite_q;
   assign psel      = psel_q;
   assign penable   = penable_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Randomized bench for apb_cmd_master: the bench plays the APB slave and checks responses against a register-map model.
module tb_apb_cmd_master;

   localparam int ADDR_W  = 12;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;

   logic              pclk;
   logic              prstn;
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic              pwrite;
   logic              psel;
   logic              penable;
   logic [DATA_W-1:0] prdata;
   logic              pready;

   int total = 0;
   int bad   = 0;

   // Slave registers (written from observed APB traffic) and reference registers (written from issued commands).
   logic [31:0] slv_mem [4];
   logic [31:0] ref_mem [4];

   apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .pclk(pclk), .prstn(prstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
      .prdata(prdata), .pready(pready)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic bit is_mapped(input logic [11:0] a);
      return (a[11:4] == 8'h30) && (a[1:0] == 2'b00);
   endfunction

   function automatic logic [31:0] slave_read(input logic [11:0] a);
      return is_mapped(a) ? slv_mem[a[3:2]] : 32'hDEADBEEF;
   endfunction

   function automatic logic [31:0] model_read(input logic [11:0] a);
      return is_mapped(a) ? ref_mem[a[3:2]] : 32'hDEADBEEF;
   endfunction

   // One command: waits = ACCESS cycles the slave holds pready low, hold = cycles rsp_ready is withheld.
   task automatic do_cmd(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                         input int waits, input int hold);
      logic [31:0] exp_rd;
      bit          exp_err;
      bit          done;
      int          n;
      exp_err = (TIMEOUT != 0) && (waits >= TIMEOUT);
      exp_rd  = (wr || exp_err) ? 32'h0 : model_read(addr);
      if (wr && !exp_err && is_mapped(addr)) ref_mem[addr[3:2]] = wd;

      @(negedge pclk);
      check_eq("idle_cmd_ready", cmd_ready, 1);
      check_eq("idle_psel", psel, 0);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
      pready = 1'b0; rsp_ready = 1'b0;

      @(posedge pclk); @(negedge pclk);
      // Stray command while busy must be ignored.
      cmd_valid = 1'($urandom); cmd_write = 1'($urandom);
      cmd_addr = 12'($urandom); cmd_wdata = $urandom;
      pready = 1'($urandom);
      check_eq("setup_psel", psel, 1);
      check_eq("setup_penable", penable, 0);
      check_eq("setup_paddr", 32'(paddr), 32'(addr));
      check_eq("setup_pwrite", pwrite, wr);
      check_eq("setup_pwdata", pwdata, wd);
      check_eq("setup_cmd_ready", cmd_ready, 0);
      check_eq("setup_rsp_valid", rsp_valid, 0);

      n = 0; done = 1'b0;
      while (!done) begin
         @(posedge pclk); @(negedge pclk);
         check_eq("acc_psel", psel, 1);
         check_eq("acc_penable", penable, 1);
         check_eq("acc_paddr", 32'(paddr), 32'(addr));
         check_eq("acc_pwdata", pwdata, wd);
         check_eq("acc_pwrite", pwrite, wr);
         pready = (n >= waits);
         prdata = pready ? slave_read(paddr) : $urandom;
         if (pready && pwrite && is_mapped(paddr)) slv_mem[paddr[3:2]] = pwdata;
         if (pready) done = 1'b1;
         else if ((TIMEOUT != 0) && (n == TIMEOUT - 1)) done = 1'b1;
         n++;
      end

      @(posedge pclk); @(negedge pclk);
      pready = 1'b0;
      cmd_valid = 1'b1; cmd_addr = 12'($urandom); cmd_write = 1'($urandom);
      check_eq("rsp_valid", rsp_valid, 1);
      check_eq("rsp_rdata", rsp_rdata, exp_rd);
      check_eq("rsp_err", rsp_err, exp_err);
      check_eq("rsp_psel", psel, 0);
      check_eq("rsp_penable", penable, 0);
      check_eq("rsp_cmd_ready", cmd_ready, 0);
      for (int h = 0; h < hold; h++) begin
         @(posedge pclk); @(negedge pclk);
         check_eq("hold_rsp_valid", rsp_valid, 1);
         check_eq("hold_rsp_rdata", rsp_rdata, exp_rd);
         check_eq("hold_rsp_err", rsp_err, exp_err);
         check_eq("hold_cmd_ready", cmd_ready, 0);
         check_eq("hold_psel", psel, 0);
         check_eq("hold_paddr", 32'(paddr), 32'(addr));
      end
      rsp_ready = 1'b1;
      @(posedge pclk); @(negedge pclk);
      rsp_ready = 1'b0; cmd_valid = 1'b0;
      check_eq("post_rsp_valid", rsp_valid, 0);
      check_eq("post_cmd_ready", cmd_ready, 1);
      check_eq("post_psel", psel, 0);
      check_eq("post_paddr", 32'(paddr), 32'(addr));
      check_eq("post_pwrite", pwrite, wr);
   endtask

   task automatic reset_in_access(input logic [11:0] addr);
      @(negedge pclk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_wdata = 32'h0;
      pready = 1'b0; rsp_ready = 1'b0;
      @(posedge pclk); @(negedge pclk);
      cmd_valid = 1'b0;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      check_eq("pre_rst_penable", penable, 1);
      prstn = 1'b0;
      @(posedge pclk); @(negedge pclk);
      check_eq("mid_rst_psel", psel, 0);
      check_eq("mid_rst_penable", penable, 0);
      check_eq("mid_rst_rsp_valid", rsp_valid, 0);
      check_eq("mid_rst_cmd_ready", cmd_ready, 0);
      check_eq("mid_rst_paddr", 32'(paddr), 0);
      prstn = 1'b1;
      @(posedge pclk); @(negedge pclk);
      check_eq("after_rst_cmd_ready", cmd_ready, 1);
      check_eq("after_rst_rsp_valid", rsp_valid, 0);
   endtask

   initial begin
      logic [11:0] a;
      int          w;
      for (int i = 0; i < 4; i++) begin
         slv_mem[i] = 32'h0;
         ref_mem[i] = 32'h0;
      end
      slv_mem[2] = 32'h0000_0010;
      ref_mem[2] = 32'h0000_0010;
      prstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0; prdata = '0; pready = 1'b0;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      check_eq("reset_cmd_ready", cmd_ready, 0);
      check_eq("reset_rsp_valid", rsp_valid, 0);
      check_eq("reset_psel", psel, 0);
      check_eq("reset_penable", penable, 0);
      check_eq("reset_paddr", 32'(paddr), 0);
      check_eq("reset_pwdata", pwdata, 0);
      check_eq("reset_pwrite", pwrite, 0);
      check_eq("reset_rsp_rdata", rsp_rdata, 0);
      check_eq("reset_rsp_err", rsp_err, 0);
      prstn = 1'b1;

      do_cmd(1'b1, 12'h300, 32'h1234_5678, 0, 0);
      do_cmd(1'b0, 12'h308, 32'h0, 0, 0);
      do_cmd(1'b0, 12'h7FC, 32'h0, 0, 0);
      do_cmd(1'b0, 12'h300, 32'h0, 3, 0);
      do_cmd(1'b0, 12'h304, 32'h0, TIMEOUT, 0);
      do_cmd(1'b1, 12'h304, 32'hA5A5_5A5A, TIMEOUT - 1, 5);
      do_cmd(1'b0, 12'h304, 32'h0, 0, 0);
      do_cmd(1'b1, 12'h308, 32'hCAFE_F00D, TIMEOUT + 2, 2);
      do_cmd(1'b0, 12'h308, 32'h0, 0, 1);
      reset_in_access(12'h304);
      do_cmd(1'b0, 12'h300, 32'h0, 0, 0);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 5))
            0: a = 12'h300;
            1: a = 12'h304;
            2: a = 12'h308;
            3: a = 12'h30C;
            4: a = 12'h7FC;
            default: a = 12'($urandom);
         endcase
         w = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3) : $urandom_range(4, 20);
         do_cmd(1'($urandom), a, $urandom, w, $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
